// File: rtl/banco_registros_wr.sv
// banco_registros_wr: write-responder register bank for the Jericalla datapath.
//
// A write request (i_e_write_br) is latched and held pending until the next
// frame boundary (i_sel_demux). At that boundary the request is written to
// the array, and o_wr_ack pulses for one cycle.
// While a request is pending, a newer request replaces it (last-wins), and
// o_overwrite_cnt counts each replacement.
// Two synchronous read ports feed the ALU operand path.
// Address 0 is hardwired to zero.
//
// Optional feature, selected by the macro BR_BYPASS_EN:
//   defined   - a read of the committing address in the commit cycle returns
//               the new data on that same edge (write-through forwarding).
//   undefined - that read returns the old array contents; the new value is
//               visible one cycle later.
//
// Handshake: a request is taken on any edge where i_e_write_br=1 and the FSM
// is in IDLE or ACK. It is never back-pressured. o_busy=1 (PENDING) marks a
// held request. The request commits on the edge where PENDING and
// i_sel_demux=1 are sampled. o_wr_ack is high for exactly the following cycle.
//
// o_dbg_state exposes the FSM state: 0=IDLE, 1=PENDING, 2=ACK.
module banco_registros_wr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_e_write_br,
  input  logic              i_sel_demux,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_wr_ack,
  output logic              o_busy,
  output logic [7:0]        o_overwrite_cnt,
  output logic [1:0]        o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_data_q, lat_data_d;
  logic [7:0]          ovw_cnt_q, ovw_cnt_d;
  logic                commit;
  logic [DATA_W-1:0]   rd_a_q, rd_a_d;
  logic [DATA_W-1:0]   rd_b_q, rd_b_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Next-state logic: request latching, the commit decision and overwrite counting.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    ovw_cnt_d  = ovw_cnt_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE, S_ACK: begin
        // A boundary pulse here has nothing to commit.
        // A coincident request is only latched.
        if (i_e_write_br) begin
          lat_addr_d = i_wr_addr;
          lat_data_d = i_wr_data;
          state_d    = S_PENDING;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        if (i_sel_demux) begin
          // The held request wins; a coincident new request is dropped.
          commit  = 1'b1;
          state_d = S_ACK;
          if (i_e_write_br && ovw_cnt_q != 8'hFF) begin
            ovw_cnt_d = ovw_cnt_q + 8'd1;
          end
        end else if (i_e_write_br) begin
          lat_addr_d = i_wr_addr;
          lat_data_d = i_wr_data;
          if (ovw_cnt_q != 8'hFF) begin
            ovw_cnt_d = ovw_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with the latched request and the saturating counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      ovw_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      ovw_cnt_q  <= ovw_cnt_d;
    end
  end

  // Register array. Commits to address 0 are discarded, so entry 0 stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && lat_addr_q != '0) begin
      mem_q[lat_addr_q] <= lat_data_q;
    end
  end

  // Read-port data selection, with optional forwarding of the committing write.
  always_comb begin
    rd_a_d = (i_rd_addr_a == '0) ? '0 : mem_q[i_rd_addr_a];
    rd_b_d = (i_rd_addr_b == '0) ? '0 : mem_q[i_rd_addr_b];
`ifdef BR_BYPASS_EN
    if (commit && lat_addr_q != '0 && i_rd_addr_a == lat_addr_q) begin
      rd_a_d = lat_data_q;
    end
    if (commit && lat_addr_q != '0 && i_rd_addr_b == lat_addr_q) begin
      rd_b_d = lat_data_q;
    end
`endif
  end

  // Registered read ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign o_rd_data_a     = rd_a_q;
  assign o_rd_data_b     = rd_b_q;
  assign o_busy          = (state_q == S_PENDING);
  assign o_wr_ack        = (state_q == S_ACK);
  assign o_overwrite_cnt = ovw_cnt_q;
  assign o_dbg_state     = state_q;

endmodule
